slow_edge_meter: RTL and testbench
==================================

Name: slow_edge_meter

Overview:
- Consumer side of the clock-divider path: takes a slow square wave back into the fast CLOCK domain.
- Synchronises the slow input, emits single-cycle RISE/FALL strobes, and measures period and high time in CLOCK cycles.
- Flags loss of the slow signal through a timeout.
- Used to drive fast-domain logic from divider outputs or external slow signals, and to self-check the divider ratio.

Parameters:
- CNT_W, 24, width of the period/high-time counters and outputs.
- SYNC_STAGES, 2, synchroniser flops on SLOW_IN; legal range 2..4.
- TIMEOUT_LIMIT, 24'd16_000_000, cycles without a rise event before TIMEOUT is set. Must satisfy 2 <= value <= 2^CNT_W-1.

Ports:
- CLOCK  in  1  fast system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SLOW_IN  in  1  slow input, asynchronous to CLOCK.
- ENABLE  in  1  measurement enable.
- RISE  out  1  one-cycle strobe per synchronised rising edge.
- FALL  out  1  one-cycle strobe per synchronised falling edge.
- PERIOD  out  CNT_W  last measured rise-to-rise interval, in cycles.
- HIGH_TIME  out  CNT_W  last measured rise-to-fall interval, in cycles.
- VALID  out  1  one-cycle strobe when PERIOD/HIGH_TIME update.
- TIMEOUT  out  1  sticky flag: no rise seen within TIMEOUT_LIMIT.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - All synchroniser flops and prev-sample = 0.
  - RISE = FALL = VALID = TIMEOUT = 0; PERIOD = HIGH_TIME = 0.
  - Counter = 0, state = IDLE.
  - Reset mid-measurement discards the partial count with no VALID.
- Synchroniser and edge detection:
  - s[0] samples SLOW_IN; s[SYNC_STAGES-1] is the synced value `ss`; `sp` is a one-cycle delay of `ss`.
  - RISE is registered: 1 for exactly one cycle when ss=1 and sp=0. FALL likewise for ss=0 and sp=1.
  - Latency: SLOW_IN stable high before edge k gives RISE high in the cycle after edge k+SYNC_STAGES (3 edges for the default).
  - RISE and FALL are never both 1 in the same cycle.
  - RISE/FALL are produced regardless of ENABLE and state.
- States:
  - IDLE: counter held at 0. Enters ARM when ENABLE=1.
  - ARM: waits for the first rise event, which sets counter=1 and moves to MEASURE. No VALID is produced for this first rise.
  - MEASURE:
    - Counter increments by 1 each cycle.
    - Fall event: hi_reg <= counter.
    - Rise event: PERIOD <= counter, HIGH_TIME <= hi_reg, VALID=1 for one cycle, counter <= 1, TIMEOUT <= 0.
- Measurement results:
  - For a divider with half-period H (toggle every H cycles), steady state gives PERIOD = 2H and HIGH_TIME = H.
  - If no fall occurred since the last rise, HIGH_TIME reports the stale hi_reg value.
- Timeout:
  - Applies in ARM or MEASURE. If the counter reaches TIMEOUT_LIMIT with no rise event: TIMEOUT <= 1, counter <= 0, state <= ARM.
  - PERIOD and HIGH_TIME hold; no VALID.
  - In ARM the counter increments for timeout purposes only; the next rise reloads it to 1.
  - TIMEOUT clears only on the next VALID or on reset.
- Simultaneous events:
  - A rise event in the same cycle the counter hits TIMEOUT_LIMIT: the rise wins (VALID issued, no TIMEOUT).
  - ENABLE falling in any state: next state IDLE, counter 0, no VALID that cycle. Outputs and TIMEOUT hold.
- Widths and limits:
  - The counter never wraps; TIMEOUT_LIMIT <= 2^CNT_W-1 guarantees timeout before overflow.
  - Pulses shorter than SYNC_STAGES+1 cycles may be missed; this is accepted behaviour.

Test Plan:
- Reset release with SLOW_IN=0, ENABLE=1, no edges for 100 cycles -> RISE=FALL=VALID=TIMEOUT=0, PERIOD=0.
- SLOW_IN square wave toggling every 4 cycles, ENABLE=1 -> first rise gives no VALID; every later rise gives VALID one cycle wide with PERIOD=8, HIGH_TIME=4. RISE is 3 cycles after the SLOW_IN edge.
- Asymmetric wave, high 3 / low 7 cycles -> PERIOD=10, HIGH_TIME=3. Exactly one RISE and one FALL per period.
- TIMEOUT_LIMIT=50: stop the wave after a valid measurement -> TIMEOUT=1 exactly 50 cycles after the last counter reload, PERIOD held at 8. Restart the wave -> first rise only re-arms; second rise gives VALID and TIMEOUT=0.
- Assert RESET_N low mid-period and mid-RISE-pulse -> all outputs 0 immediately (asynchronously). After release, behaviour matches a fresh start.
- Drop ENABLE for 20 cycles mid-measurement -> no VALID while low. After re-enable, first rise only arms; next rise gives the correct PERIOD.

Source files
------------

// File: rtl/slow_edge_meter.sv
// Slow-signal edge meter: brings a slow square wave into the CLOCK domain, strobes its edges,
// measures rise-to-rise period and rise-to-fall high time, and flags loss of signal.
module slow_edge_meter #(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned TIMEOUT_LIMIT = 16_000_000
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             SLOW_IN,
  input  logic             ENABLE,
  output logic             RISE,
  output logic             FALL,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic             VALID,
  output logic             TIMEOUT
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(TIMEOUT_LIMIT);
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sp;
  logic                   r_rise;
  logic                   r_fall;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hi;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high;
  logic                   r_valid;
  logic                   r_timeout;

  logic                   w_ss;
  logic                   w_rise_evt;
  logic                   w_fall_evt;
  logic [1:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_hi_nxt;
  logic [CNT_W-1:0]       w_period_nxt;
  logic [CNT_W-1:0]       w_high_nxt;
  logic                   w_valid_nxt;
  logic                   w_timeout_nxt;

  assign w_ss       = r_sync[SYNC_STAGES-1];
  assign w_rise_evt = w_ss & ~r_sp;
  assign w_fall_evt = ~w_ss & r_sp;

  // Synchroniser chain, delayed copy of the synced value, and registered edge strobes.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync <= '0;
      r_sp   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], SLOW_IN};
      r_sp   <= w_ss;
      r_rise <= w_rise_evt;
      r_fall <= w_fall_evt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_period_nxt  = r_period;
    w_high_nxt    = r_high;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = r_timeout;

    if (!ENABLE) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ARM;
          w_cnt_nxt   = '0;
        end
        // The first rise only starts the count; the counter runs here solely for the timeout.
        ST_ARM: begin
          if (w_rise_evt) begin
            w_state_nxt = ST_MEAS;
            w_cnt_nxt   = LP_ONE;
          end else if (r_cnt == LP_LIMIT) begin
            w_timeout_nxt = 1'b1;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + LP_ONE;
          end
        end
        ST_MEAS: begin
          if (w_fall_evt) begin
            w_hi_nxt = r_cnt;
          end
          // A rise on the limit cycle still counts as a good measurement.
          if (w_rise_evt) begin
            w_period_nxt  = r_cnt;
            w_high_nxt    = r_hi;
            w_valid_nxt   = 1'b1;
            w_timeout_nxt = 1'b0;
            w_cnt_nxt     = LP_ONE;
          end else if (r_cnt == LP_LIMIT) begin
            w_timeout_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_ARM;
          end else begin
            w_cnt_nxt = r_cnt + LP_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_period  <= w_period_nxt;
      r_high    <= w_high_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign RISE      = r_rise;
  assign FALL      = r_fall;
  assign PERIOD    = r_period;
  assign HIGH_TIME = r_high;
  assign VALID     = r_valid;
  assign TIMEOUT   = r_timeout;

endmodule

// File: tb/tb_slow_edge_meter.sv
// Bench for slow_edge_meter: timestamp-based reference model feeding a scoreboard queue,
// directed scenarios plus randomized waves, enable drops and asynchronous resets.
module tb_slow_edge_meter;

  localparam int CNT_W = 24;
  localparam int SYNC  = 2;
  localparam int LIMIT = 50;

  logic             CLOCK   = 1'b0;
  logic             RESET_N = 1'b0;
  logic             SLOW_IN = 1'b0;
  logic             ENABLE  = 1'b0;
  logic             RISE;
  logic             FALL;
  logic [CNT_W-1:0] PERIOD;
  logic [CNT_W-1:0] HIGH_TIME;
  logic             VALID;
  logic             TIMEOUT;

  slow_edge_meter #(
    .CNT_W        (CNT_W),
    .SYNC_STAGES  (SYNC),
    .TIMEOUT_LIMIT(LIMIT)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .SLOW_IN  (SLOW_IN),
    .ENABLE   (ENABLE),
    .RISE     (RISE),
    .FALL     (FALL),
    .PERIOD   (PERIOD),
    .HIGH_TIME(HIGH_TIME),
    .VALID    (VALID),
    .TIMEOUT  (TIMEOUT)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int period;
    int high;
  } meas_t;

  meas_t exp_q[$];

  bit m_in_hist[0:SYNC];   // m_in_hist[k] = SLOW_IN sampled k+1 edges ago
  int m_mode;              // 0 idle, 1 waiting for first rise, 2 measuring
  int m_edge;
  int m_base;              // count value before edge n is n - m_base
  int m_hi;
  bit exp_rise, exp_fall, exp_valid, exp_to;

  task automatic m_reset();
    for (int k = 0; k <= SYNC; k++) m_in_hist[k] = 1'b0;
    m_mode = 0; m_base = 0; m_hi = 0;
    exp_rise = 0; exp_fall = 0; exp_valid = 0; exp_to = 0;
  endtask

  task automatic m_step();
    bit ss, sp, rise, fall;
    int cnt;
    m_edge++;
    ss   = m_in_hist[SYNC-1];
    sp   = m_in_hist[SYNC];
    rise = ss && !sp;
    fall = !ss && sp;
    exp_rise  = rise;
    exp_fall  = fall;
    exp_valid = 0;
    cnt = m_edge - m_base;
    if (!ENABLE) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_base = m_edge + 1;
    end else if (m_mode == 1) begin
      if (rise) begin
        m_mode = 2;
        m_base = m_edge;
      end else if (cnt == LIMIT) begin
        exp_to = 1;
        m_base = m_edge + 1;
      end
    end else begin
      if (fall) m_hi = cnt;
      if (rise) begin
        exp_q.push_back('{period: cnt, high: (fall ? cnt : m_hi)});
        exp_valid = 1;
        exp_to    = 0;
        m_base    = m_edge;
      end else if (cnt == LIMIT) begin
        exp_to = 1;
        m_mode = 1;
        m_base = m_edge + 1;
      end
    end
    for (int k = SYNC; k > 0; k--) m_in_hist[k] = m_in_hist[k-1];
    m_in_hist[0] = SLOW_IN;
  endtask

  initial begin
    m_edge = 0;
    m_reset();
    forever begin
      @(posedge CLOCK or negedge RESET_N);
      if (!RESET_N) begin
        m_reset();
        exp_q.delete();
      end else begin
        m_step();
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int  cyc = 0;
  int  n_rise_seen = 0;
  int  n_fall_seen = 0;
  int  last_valid_cyc = 0;
  int  to_rise_cyc = 0;
  int  last_period = 0;
  int  last_high = 0;
  bit  prev_to = 0;

  initial begin
    meas_t it;
    forever begin
      @(negedge CLOCK);
      cyc++;
      chk("RISE", RISE, exp_rise);
      chk("FALL", FALL, exp_fall);
      chk("VALID", VALID, exp_valid);
      chk("TIMEOUT", TIMEOUT, exp_to);
      if (RISE) n_rise_seen++;
      if (FALL) n_fall_seen++;
      if (TIMEOUT && !prev_to) to_rise_cyc = cyc;
      prev_to = TIMEOUT;
      if (VALID) begin
        last_valid_cyc = cyc;
        last_period = int'(PERIOD);
        last_high   = int'(HIGH_TIME);
        if (exp_q.size() == 0) begin
          chk("unexpected VALID", 1, 0);
        end else begin
          it = exp_q.pop_front();
          chk("PERIOD", PERIOD, it.period);
          chk("HIGH_TIME", HIGH_TIME, it.high);
        end
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        chk("missing VALID", 0, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  // Called on a negedge; per-cycle square wave with an optional ENABLE-low window.
  task automatic drive(input int hi, input int lo, input int ncyc, input int off_at,
                       input int off_len);
    for (int i = 0; i < ncyc; i++) begin
      SLOW_IN = ((i % (hi + lo)) < hi);
      ENABLE  = !(i >= off_at && i < off_at + off_len);
      @(negedge CLOCK);
    end
    ENABLE = 1'b1;
  endtask

  task automatic async_reset(input int dly);
    #(dly);
    RESET_N = 1'b0;
    #1;
    chk("rst RISE", RISE, 0);
    chk("rst FALL", FALL, 0);
    chk("rst VALID", VALID, 0);
    chk("rst TIMEOUT", TIMEOUT, 0);
    chk("rst PERIOD", PERIOD, 0);
    chk("rst HIGH_TIME", HIGH_TIME, 0);
    tick(2);
    RESET_N = 1'b1;
  endtask

  initial begin
    int r0, f0, lat, dly;
    bit seen;
    tick(3);
    RESET_N = 1'b1;
    ENABLE  = 1'b1;
    // quiet input after reset
    r0 = n_rise_seen; f0 = n_fall_seen;
    tick(40);
    chk("quiet TIMEOUT", TIMEOUT, 0);
    chk("quiet PERIOD", PERIOD, 0);
    chk("quiet HIGH_TIME", HIGH_TIME, 0);
    tick(60);
    chk("quiet rises", n_rise_seen - r0, 0);
    chk("quiet falls", n_fall_seen - f0, 0);

    // edge-to-strobe latency
    SLOW_IN = 1'b1;
    lat = 0; seen = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge CLOCK);
      if (RISE) begin lat = i; seen = 1; end
    end
    chk("RISE latency", lat, 3);

    // symmetric wave, half-period 4
    drive(4, 4, 48, -1, 0);
    chk("sym PERIOD", last_period, 8);
    chk("sym HIGH_TIME", last_high, 4);

    // asymmetric wave, high 3 / low 7
    tick(5);
    r0 = n_rise_seen; f0 = n_fall_seen;
    drive(3, 7, 50, -1, 0);
    tick(5);
    chk("asym PERIOD", last_period, 10);
    chk("asym HIGH_TIME", last_high, 3);
    chk("asym rises", n_rise_seen - r0, 5);
    chk("asym falls", n_fall_seen - f0, 5);

    // loss of signal, then restart
    drive(4, 4, 32, -1, 0);
    SLOW_IN = 1'b0;
    tick(80);
    chk("timeout set", TIMEOUT, 1);
    chk("timeout delay", to_rise_cyc - last_valid_cyc, LIMIT);
    chk("timeout PERIOD held", PERIOD, 8);
    drive(4, 4, 24, -1, 0);
    tick(4);
    chk("restart TIMEOUT", TIMEOUT, 0);
    chk("restart PERIOD", last_period, 8);

    // asynchronous reset mid-period and mid-RISE pulse
    drive(4, 4, 13, -1, 0);
    async_reset(3);
    drive(4, 4, 30, -1, 0);
    SLOW_IN = 1'b0;
    tick(6);
    SLOW_IN = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLOCK);
      if (RISE) seen = 1;
    end
    chk("RISE before reset", seen, 1);
    async_reset(1);
    drive(4, 4, 40, -1, 0);

    // ENABLE dropped for 20 cycles mid-measurement
    drive(4, 4, 80, 21, 20);
    chk("enable-drop PERIOD", last_period, 8);

    // randomized waves, enable drops and resets
    for (int it = 0; it < 30; it++) begin
      drive($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(40, 160),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1,
            $urandom_range(1, 25));
      if ($urandom_range(0, 4) == 0) begin
        SLOW_IN = 1'b0;
        tick($urandom_range(10, 120));
      end
      if ($urandom_range(0, 6) == 0) begin
        dly = $urandom_range(1, 3);
        async_reset(dly);
      end
    end

    SLOW_IN = 1'b0;
    tick(10);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
